// File: rtl/dac_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_rx
// Purpose  : SPI slave receiver for the 12-bit DAC frame (10 data bits MSB
//            first, then 2 pad bits, chip select active low). The SPI pins
//            are oversampled in the s_clk domain. Each spi_clk rising edge
//            shifts in one bit, and the frame length is checked when chip
//            select is released.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports    : s_clk     in   system clock (at least 4x spi_clk)
//            s_rst     in   asynchronous active-high reset
//            spi_clk   in   serial clock, idles low, sample on rising edge
//            spi_cs_n  in   frame select, active low
//            mosi      in   serial data
//            data_out  out  last valid payload, held between frames
//            data_vld  out  one-cycle pulse when data_out updates
//            frame_err out  one-cycle pulse on a short, long or aborted frame
//            busy      out  high while a frame is being received
// Options  : define DAC_SPI_RX_TIMEOUT_EN to abort frames whose spi_clk
//            stalls for TIMEOUT s_clk cycles
// ============================================================================
module dac_spi_rx #(
    parameter int FRAME_BITS  = 12,
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              mosi,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [4:0] c_frame_cnt = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CHECK   = 2'd2
`ifdef DAC_SPI_RX_TIMEOUT_EN
        ,ST_WAIT_CS = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_clk_d;
    logic                   r_cs_fall;
    logic                   r_cs_rise;
    logic                   r_clk_rise;
    logic                   r_mosi_q;
    // Becomes set once the history register holds a real pin sample
    // rather than its reset preset.
    logic [SYNC_STAGES:0]   r_prime;
    // Only a cs_fall seen after cs has been observed high starts a frame,
    // so a frame already in progress when reset is released is ignored.
    logic                   r_armed;

    logic w_cs;
    logic w_clk;
    logic w_mosi;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Edge pulses are registered; mosi is delayed by the same amount so
    // that the shifted bit stays aligned with its clk_rise pulse.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_cs_sync   <= '1;
            r_clk_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_clk_d     <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_clk_rise  <= 1'b0;
            r_mosi_q    <= 1'b0;
            r_prime     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_d      <= w_cs;
            r_clk_d     <= w_clk;
            r_cs_fall   <= r_cs_d & ~w_cs;
            r_cs_rise   <= ~r_cs_d & w_cs;
            r_clk_rise  <= ~r_clk_d & w_clk;
            r_mosi_q    <= w_mosi;
            r_prime     <= {r_prime[SYNC_STAGES-1:0], 1'b1};
            if (r_cs_rise || (r_prime[SYNC_STAGES] && r_cs_d))
                r_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_bit_cnt;
    logic                  w_clear;
    logic                  w_shift_en;
    logic                  w_vld;
    logic                  w_err;

`ifdef DAC_SPI_RX_TIMEOUT_EN
    logic [7:0] r_idle;
    logic [7:0] w_idle_inc;
    assign w_idle_inc = r_idle + 8'd1;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
`endif

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_vld       = 1'b0;
        w_err       = 1'b0;
        w_shift_en  = (r_state == ST_RECV) && r_clk_rise;
        case (r_state)
            ST_IDLE: begin
                if (r_cs_fall && r_armed) begin
                    w_state_nxt = ST_RECV;
                    w_clear     = 1'b1;
                end
            end
            ST_RECV: begin
                // A clk_rise coinciding with cs_rise is still shifted.
                if (r_cs_rise)
                    w_state_nxt = ST_CHECK;
`ifdef DAC_SPI_RX_TIMEOUT_EN
                else if (!r_clk_rise && (w_idle_inc == 8'(TIMEOUT))) begin
                    w_state_nxt = ST_WAIT_CS;
                    w_err       = 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                if (r_bit_cnt == c_frame_cnt) w_vld = 1'b1;
                else                          w_err = 1'b1;
                // Back-to-back frame: restart directly.
                if (r_cs_fall) begin
                    w_state_nxt = ST_RECV;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef DAC_SPI_RX_TIMEOUT_EN
            ST_WAIT_CS: begin
                if (r_cs_rise) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            data_out  <= '0;
            data_vld  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (w_clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], r_mosi_q};
                if (r_bit_cnt != 5'd31)
                    r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_vld)
                data_out <= r_shift[FRAME_BITS-1 -: DATA_W];
            data_vld  <= w_vld;
            frame_err <= w_err;
            busy      <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef DAC_SPI_RX_TIMEOUT_EN
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst)
            r_idle <= '0;
        else if (w_clear || r_clk_rise)
            r_idle <= '0;
        else if (r_state == ST_RECV)
            r_idle <= w_idle_inc;
    end
`endif

endmodule
`default_nettype wire
